// File: rtl/display_scanner_pkg.sv
// Shared definitions for the multiplexed display scanner: FSM state codes,
// register map and reset constants, plus the digit-select helper.
package display_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BLANK = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_ON    = 3'd4,
        ST_OFF   = 3'd5
    } scan_state_e;

    localparam logic [3:0] ADDR_DIG0   = 4'd0;
    localparam logic [3:0] ADDR_DIG1   = 4'd1;
    localparam logic [3:0] ADDR_DIG2   = 4'd2;
    localparam logic [3:0] ADDR_DIG3   = 4'd3;
    localparam logic [3:0] ADDR_CTRL   = 4'd4;
    localparam logic [3:0] ADDR_PRE    = 4'd5;
    localparam logic [3:0] ADDR_STATUS = 4'd6;
    localparam logic [3:0] ADDR_FLAG   = 4'd7;

    localparam logic [7:0] CTRL_RST = 8'h3F;
    localparam logic [7:0] PRE_RST  = 8'hFF;

    // Digit-select pattern: one-hot on idx when lit, then mapped to the
    // configured polarity so unlit digits sit at the inactive level.
    function automatic logic [3:0] dig_sel(input logic [1:0] idx,
                                           input logic       lit,
                                           input logic       dpol);
        logic [3:0] onehot;
        onehot = lit ? (4'b0001 << idx) : 4'b0000;
        return dpol ? onehot : ~onehot;
    endfunction

endpackage

// File: rtl/display_scan_tick.sv
// Prescaler plus 4-bit tick counter for the scanner's on/off timing.
// The prescaler compares with >= against the live PRE value, so lowering
// PRE below the current count produces a tick instead of a long wrap.
module display_scan_tick
    import display_scanner_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       run_i,
    input  logic [7:0] pre_i,
    output logic       tick_o,
    output logic [3:0] cnt_o
);

    logic [7:0] presc_q;
    logic [7:0] presc_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign tick_o = run_i && (presc_q >= pre_i);
    assign cnt_o  = cnt_q;

    // Next-state for prescaler and tick counter; clear has priority.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            presc_d = 8'h00;
            cnt_d   = 4'h0;
        end else if (run_i) begin
            if (tick_o) begin
                presc_d = 8'h00;
                cnt_d   = cnt_q + 4'd1;
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 8'h00;
            cnt_q   <= 4'h0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/tqvp_rebeccargb_display_scanner.sv
// Multiplexed 4-digit display scanner: shifts segment bytes into an
// external 74HC595-style latch and time-multiplexes the digit selects.
// Optional feature: define DISPLAY_SCANNER_FLAG_EN to build the sticky
// frame-done flag at address 7.
module tqvp_rebeccargb_display_scanner
    import display_scanner_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    logic [7:0]  dig_q [4];
    logic [7:0]  ctrl_q;
    logic [7:0]  pre_q;

    scan_state_e state_q;
    scan_state_e state_d;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [7:0]  shreg_q;
    logic [7:0]  shreg_d;
    logic [3:0]  bit_q;
    logic [3:0]  bit_d;
    logic [7:0]  out_q;
    logic [7:0]  out_d;

    logic        en_s;
    logic        dpol_s;
    logic [1:0]  ndig_m1_s;
    logic [3:0]  bright_s;
    logic        tick_s;
    logic [3:0]  tick_cnt_s;
    logic [4:0]  cnt_nxt_s;
    logic        on_done_s;
    logic        off_done_s;
    logic        last_dig_s;
    logic        tick_clr_s;
    logic        tick_run_s;
    logic [7:0]  flag_rd_s;
    logic        unused_s;

    assign unused_s   = &{1'b0, ui_in};

    assign en_s       = ctrl_q[7];
    assign dpol_s     = ctrl_q[6];
    assign ndig_m1_s  = ctrl_q[5:4];
    assign bright_s   = ctrl_q[3:0];

    // Tick count including this cycle's tick, so on-time is exactly BRIGHT ticks.
    assign cnt_nxt_s  = {1'b0, tick_cnt_s} + {4'b0000, tick_s};
    assign on_done_s  = cnt_nxt_s >= {1'b0, bright_s};
    assign off_done_s = (tick_cnt_s == 4'd15) && tick_s;
    assign last_dig_s = idx_q >= ndig_m1_s;

    assign tick_clr_s = !en_s || (state_q == ST_LATCH);
    assign tick_run_s = (state_q == ST_ON) || (state_q == ST_OFF);

    display_scan_tick u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tick_clr_s),
        .run_i (tick_run_s),
        .pre_i (pre_q),
        .tick_o(tick_s),
        .cnt_o (tick_cnt_s)
    );

    // Register file writes; read-only and unmapped addresses are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= 8'h00;
            end
            ctrl_q <= CTRL_RST;
            pre_q  <= PRE_RST;
        end else if (data_write) begin
            case (address)
                ADDR_DIG0, ADDR_DIG1, ADDR_DIG2, ADDR_DIG3: dig_q[address[1:0]] <= data_in;
                ADDR_CTRL: ctrl_q <= data_in;
                ADDR_PRE:  pre_q  <= data_in;
                default:   ;
            endcase
        end
    end

    // Scan FSM next state, index, shift snapshot and shift bit counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        if (!en_s) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            bit_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                end
                ST_BLANK: begin
                    shreg_d = dig_q[idx_q];
                    bit_d   = 4'd0;
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_q == 4'd15) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
                ST_LATCH: begin
                    bit_d   = 4'd0;
                    state_d = (bright_s == 4'd0) ? ST_OFF : ST_ON;
                end
                ST_ON: begin
                    if (on_done_s) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_ON;
                    end
                end
                ST_OFF: begin
                    if (off_done_s) begin
                        idx_d   = last_dig_s ? 2'd0 : (idx_q + 2'd1);
                        state_d = ST_BLANK;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    // Output pins derived from the next state so they register with it.
    always_comb begin
        logic       ser;
        logic       srclk;
        logic       rclk;
        logic [2:0] bit_sel;
        ser     = 1'b0;
        srclk   = 1'b0;
        rclk    = 1'b0;
        bit_sel = 3'd7 - bit_d[3:1];
        case (state_d)
            ST_SHIFT: begin
                ser   = shreg_d[bit_sel];
                srclk = bit_d[0];
            end
            ST_LATCH: begin
                rclk = 1'b1;
            end
            default: begin
                ser = 1'b0;
            end
        endcase
        out_d = {dig_sel(idx_d, state_d == ST_ON, dpol_s), rclk, srclk, ser, 1'b0};
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            shreg_q <= 8'h00;
            bit_q   <= 4'd0;
            out_q   <= 8'hF0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            out_q   <= out_d;
        end
    end

    assign uo_out = out_q;

`ifdef DISPLAY_SCANNER_FLAG_EN
    logic flag_q;
    logic flag_set_s;
    logic flag_clr_s;

    assign flag_set_s = en_s && (state_q == ST_OFF) && off_done_s && last_dig_s;
    assign flag_clr_s = data_write && (address == ADDR_FLAG);

    // Sticky frame-done flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else if (flag_set_s) begin
            flag_q <= 1'b1;
        end else if (flag_clr_s) begin
            flag_q <= 1'b0;
        end
    end

    assign flag_rd_s = {7'b0000000, flag_q};
`else
    assign flag_rd_s = 8'h00;
`endif

    // Combinational register read mux.
    always_comb begin
        case (address)
            ADDR_DIG0, ADDR_DIG1, ADDR_DIG2, ADDR_DIG3: data_out = dig_q[address[1:0]];
            ADDR_CTRL:   data_out = ctrl_q;
            ADDR_PRE:    data_out = pre_q;
            ADDR_STATUS: data_out = {idx_q, state_q, 3'b000};
            ADDR_FLAG:   data_out = flag_rd_s;
            default:     data_out = 8'h00;
        endcase
    end

endmodule
